// File: rtl/bcd_conv_arbiter_if.sv
// Request/result bundle for bcd_conv_arbiter: NUM_REQ operand slots in,
// one tagged BCD result out on a valid/ready channel.
interface bcd_conv_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
);
  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 out_valid;
  logic [11:0]          out_bcd;
  logic [ID_W-1:0]      out_id;
  logic                 out_ready;

  modport master (
    output req_valid, req_data, out_ready,
    input  req_ready, out_valid, out_bcd, out_id
  );

  modport slave (
    input  req_valid, req_data, out_ready,
    output req_ready, out_valid, out_bcd, out_id
  );
endinterface

// File: rtl/bcd_conv_arbiter.sv
// Round-robin shared double-dabble binary-to-BCD converter, one bit per clock.
// Define BCD_ARB_FIXED_PRIO_EN for fixed lowest-index-wins arbitration.
module bcd_conv_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic               clk,
  input  logic               rst,
  bcd_conv_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [19:0]       sr_q, sr_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              out_valid_q, out_valid_d;
  logic [11:0]       out_bcd_q, out_bcd_d;
  logic [ID_W-1:0]   out_id_q, out_id_d;
  logic              gnt_found_s;
  logic [ID_W-1:0]   gnt_idx_s;
  logic [7:0]        gnt_op_s;
  logic [NUM_REQ-1:0] req_ready_s;
  logic [19:0]       sr_step_s;

  // One double-dabble iteration: correct each BCD nibble, then shift left.
  function automatic logic [19:0] dabble_step(input logic [19:0] v);
    logic [19:0] t;
    t = v;
    if (t[11:8] >= 4'd5) t[11:8] = t[11:8] + 4'd3;
    else                 t[11:8] = t[11:8];
    if (t[15:12] >= 4'd5) t[15:12] = t[15:12] + 4'd3;
    else                  t[15:12] = t[15:12];
    if (t[19:16] >= 4'd5) t[19:16] = t[19:16] + 4'd3;
    else                  t[19:16] = t[19:16];
    return {t[18:0], 1'b0};
  endfunction

`ifdef BCD_ARB_FIXED_PRIO_EN
  // Fixed priority: descending sweep leaves the lowest valid index.
  always_comb begin
    gnt_idx_s = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      gnt_idx_s = bus.req_valid[k] ? ID_W'(k) : gnt_idx_s;
    end
    gnt_found_s = |bus.req_valid;
  end
`else
  logic [ID_W-1:0] ptr_q, ptr_d;

  // Round robin: lowest valid index overall, overridden by the lowest at/after ptr.
  always_comb begin
    gnt_idx_s = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      gnt_idx_s = bus.req_valid[k] ? ID_W'(k) : gnt_idx_s;
    end
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      gnt_idx_s = (bus.req_valid[k] && (ID_W'(k) >= ptr_q)) ? ID_W'(k) : gnt_idx_s;
    end
    gnt_found_s = |bus.req_valid;
  end

  // Pointer advances past the winner, wrapping after the last requester.
  always_comb begin
    ptr_d = ptr_q;
    if ((state_q == IDLE) && gnt_found_s) begin
      ptr_d = (gnt_idx_s == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx_s + ID_W'(1);
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end
`endif

  // Operand mux and one-hot accept strobe for the current winner.
  always_comb begin
    gnt_op_s    = 8'd0;
    req_ready_s = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      gnt_op_s       = (gnt_idx_s == ID_W'(k)) ? bus.req_data[8*k +: 8] : gnt_op_s;
      req_ready_s[k] = (state_q == IDLE) && gnt_found_s && (gnt_idx_s == ID_W'(k));
    end
  end

  // Next-state and datapath control for IDLE -> SHIFT x8 -> DONE.
  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_bcd_d   = out_bcd_q;
    out_id_d    = out_id_q;
    sr_step_s   = dabble_step(sr_q);
    case (state_q)
      IDLE: begin
        if (gnt_found_s) begin
          sr_d     = {12'd0, gnt_op_s};
          out_id_d = gnt_idx_s;
          cnt_d    = 3'd0;
          state_d  = SHIFT;
        end else begin
          state_d  = IDLE;
        end
      end
      SHIFT: begin
        sr_d  = sr_step_s;
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          out_valid_d = 1'b1;
          out_bcd_d   = sr_step_s[19:8];
          state_d     = DONE;
        end else begin
          state_d     = SHIFT;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end else begin
          state_d     = DONE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  // State, shift register and registered result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      sr_q        <= 20'd0;
      cnt_q       <= 3'd0;
      out_valid_q <= 1'b0;
      out_bcd_q   <= 12'd0;
      out_id_q    <= '0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_bcd_q   <= out_bcd_d;
      out_id_q    <= out_id_d;
    end
  end

  assign bus.req_ready = req_ready_s;
  assign bus.out_valid = out_valid_q;
  assign bus.out_bcd   = out_bcd_q;
  assign bus.out_id    = out_id_q;

endmodule

// File: doc/bcd_conv_arbiter.md
Name: bcd_conv_arbiter

Overview:
Shares one iterative double-dabble binary-to-BCD engine among NUM_REQ requesters. Arbitration is round-robin. Each conversion is processed one bit per clock. The result is returned on a single valid/ready output channel, tagged with the requester index. It sits between display-value producers (counters, sensors, status registers) and the 7-segment/LCD digit formatting logic.

Parameters:
NUM_REQ, 4, number of requesters; legal range 2..8.
ID_W, 2, width of out_id; must equal ceil(log2(NUM_REQ)).

Ports:
clk  input  1  rising-edge clock.
rst  input  1  synchronous, active-high reset.
req_valid  input  NUM_REQ  bit i high: requester i offers req_data slice i.
req_data  input  8*NUM_REQ  requester i operand in bits [8*i+7 : 8*i], unsigned 0..255.
req_ready  output  NUM_REQ  one-hot accept strobe; bit i high means requester i's operand is captured this cycle.
out_valid  output  1  result valid.
out_bcd  output  12  three BCD digits: [11:8] hundreds, [7:4] tens, [3:0] units.
out_id  output  ID_W  index of the requester that owns out_bcd.
out_ready  input  1  downstream accepts the result when high while out_valid is high.

Behaviour:
- Reset (rst high at a clock edge) sets:
  - state = IDLE, req_ready = 0, out_valid = 0, out_bcd = 0, out_id = 0.
  - round-robin pointer = 0, internal 20-bit shift register = 0, bit counter = 0.
- Reset has priority over all other activity. Reset mid-conversion or while out_valid is high discards the operation; the result is never presented.
- States:
  - IDLE:
    - If any req_valid bit is high, grant the first set bit at or after the pointer, searching upward with wrap from NUM_REQ-1 to 0.
    - req_ready[grant] is high combinationally in this same cycle; all other req_ready bits stay 0.
    - At the clock edge: load the shift register with {12'b0, operand}, load out_id = grant, set pointer = (grant+1) mod NUM_REQ, bit counter = 0, and go to SHIFT.
    - If no request is present, stay in IDLE; the pointer is unchanged.
  - SHIFT, one iteration per cycle:
    - Each BCD nibble [11:8], [15:12], [19:16] that is >= 5 gets +3.
    - Then the whole 20-bit register shifts left 1, with 0 shifted in.
    - The bit counter increments. After the 8th iteration (counter was 7), go to DONE.
    - req_ready is 0 throughout.
  - DONE:
    - out_valid = 1; out_bcd = shift register [19:8].
    - out_bcd and out_id are held stable while out_ready is low.
    - When out_valid and out_ready are both high at an edge, clear out_valid and return to IDLE.
- Latency: the accept cycle is T. SHIFT runs T+1..T+8, and out_valid is first high at T+9. With out_ready tied high, one conversion completes every 10 cycles.
- req_ready is 0 outside IDLE. Requesters must hold req_valid and req_data until they see their ready bit.
- Changing req_data or dropping req_valid before the grant is legal; no state is kept for ungranted requests.
- A requester that withdraws its request does not block the others.
- Pointer wrap: after a grant to NUM_REQ-1 the pointer becomes 0.
- No binary input overflows: the maximum input 255 produces 0x255 (BCD), so the hundreds digit is always <= 2.

Optional Feature:
Macro BCD_ARB_FIXED_PRIO_EN.
- Defined: fixed-priority arbitration; the lowest-index requester with req_valid high always wins, and the pointer logic is removed.
- Undefined (default): round-robin arbitration as described in Behaviour.
- All other timing and the handshake are identical in both modes.

Test Plan:
1. After reset, only requester 0 requests 8'd0 with out_ready=1 -> req_ready=4'b0001 in the accept cycle; out_valid high exactly 9 cycles later with out_bcd=12'h000 and out_id=0.
2. Single-request sweep over 1, 9, 10, 42, 99, 100, 127, 255 -> out_bcd = 12'h001, 12'h009, 12'h010, 12'h042, 12'h099, 12'h100, 12'h127, 12'h255.
3. All four requesters held valid continuously (data 11, 22, 33, 44) -> grants in order 0, 1, 2, 3, 0; out_id follows the same order; results 12'h011, 12'h022, 12'h033, 12'h044.
4. out_ready held low for 5 cycles after out_valid rises, with 200 in flight -> out_bcd=12'h200 and out_id stay stable; no req_ready is asserted; IDLE is re-entered one cycle after out_ready goes high.
5. rst asserted during SHIFT iteration 4 -> next cycle all outputs are 0 and state is IDLE; a subsequent request to requester 2 with 77 is granted (pointer back at 0) and returns 12'h077.
6. With BCD_ARB_FIXED_PRIO_EN defined, requesters 1 and 3 continuously valid -> requester 1 is granted every time and requester 3 is never granted.
